// File: rtl/pipe_mem_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM-stage data ports; data wins unless fetch starved.
// Optional stall/starvation counters are present when ARB_PERF_CNT_EN is defined.
module pipe_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [DW-1:0]     if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [AW-1:0]     dm_addr,
    input  logic [DW-1:0]     dm_wdata,
    input  logic [DW/8-1:0]   dm_be,
    output logic              dm_stall,
    output logic              dm_rvalid,
    output logic              dm_wack,
    output logic [DW-1:0]     dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_be,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DW-1:0]     mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_dm_stall,
    output logic [31:0]       perf_starve_hit
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_owner;        // 1 = data port owns the transaction
    logic [3:0]         r_starve_cnt;
    logic               r_mem_we;
    logic [AW-1:0]      r_mem_addr;
    logic [DW-1:0]      r_mem_wdata;
    logic [DW/8-1:0]    r_mem_be;
    logic [DW-1:0]      r_if_rdata;
    logic [DW-1:0]      r_dm_rdata;
    logic               w_idle;
    logic               w_grant_dm;
    logic               w_grant_if;

    assign w_idle     = (r_state == S_IDLE);
    assign w_grant_dm = w_idle & dm_req & (~if_req | (r_starve_cnt < STARVE_LIM));
    assign w_grant_if = w_idle & if_req & ~w_grant_dm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_grant_dm | w_grant_if) w_state_nxt = S_REQ;
            S_REQ:  if (mem_ready) w_state_nxt = r_mem_we ? S_IDLE : S_RESP;
            S_RESP: if (mem_rvalid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        dm_wack   = 1'b0;
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        case (r_state)
            S_REQ: begin
                mem_req = 1'b1;
                dm_wack = mem_ready & r_mem_we;
            end
            S_RESP: begin
                if_rvalid = mem_rvalid & ~r_owner;
                dm_rvalid = mem_rvalid & r_owner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else if (w_grant_dm) begin
            r_owner     <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_mem_be    <= dm_be;
        end else if (w_grant_if) begin
            r_owner     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_be    <= '1;
        end
    end

    // Counts data grants that bypassed a waiting fetch; cleared once fetch wins or stops asking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_idle) begin
            if (w_grant_dm & if_req) begin
                if (r_starve_cnt != STARVE_LIM) r_starve_cnt <= r_starve_cnt + 4'd1;
            end else if (w_grant_if | ~if_req) begin
                r_starve_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (if_rvalid) r_if_rdata <= mem_rdata;
            if (dm_rvalid) r_dm_rdata <= mem_rdata;
        end
    end

    assign if_rdata  = if_rvalid ? mem_rdata : r_if_rdata;
    assign dm_rdata  = dm_rvalid ? mem_rdata : r_dm_rdata;
    assign if_stall  = if_req & ~if_rvalid;
    assign dm_stall  = dm_req & ~(dm_rvalid | dm_wack);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_if_stall;
    logic [31:0] r_perf_dm_stall;
    logic [31:0] r_perf_starve_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_if_stall   <= '0;
            r_perf_dm_stall   <= '0;
            r_perf_starve_hit <= '0;
        end else begin
            if (if_stall) r_perf_if_stall <= r_perf_if_stall + 32'd1;
            if (dm_stall) r_perf_dm_stall <= r_perf_dm_stall + 32'd1;
            if (w_grant_if & dm_req) r_perf_starve_hit <= r_perf_starve_hit + 32'd1;
        end
    end

    assign perf_if_stall   = r_perf_if_stall;
    assign perf_dm_stall   = r_perf_dm_stall;
    assign perf_starve_hit = r_perf_starve_hit;
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter with a reactive memory model and scoreboard queues.
module tb_pipe_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_stall, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] dm_addr = '0, dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic        dm_stall, dm_rvalid, dm_wack;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall, perf_dm_stall, perf_starve_hit;
`endif

    pipe_mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_stall(dm_stall), .dm_rvalid(dm_rvalid),
        .dm_wack(dm_wack), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_stall(perf_if_stall), .perf_dm_stall(perf_dm_stall),
        .perf_starve_hit(perf_starve_hit)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t        txn_q[$];
    logic [31:0] if_exp_q[$];
    logic [31:0] dm_exp_q[$];
    int          wack_pend = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          ready_dly = 0;
    int          resp_gap = 1;
    int          wait_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_addr = '0;
    int          stray_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0113;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic txn_t mk_txn(input logic we, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] be);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = wd; t.be = be;
        return t;
    endfunction

    // sel 0: if_rvalid, 1: dm_rvalid
    task automatic wait_rv(input int sel, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!((sel == 0) ? if_rvalid : dm_rvalid) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_in_time"}, (k < 100), 1);
    endtask

    // Memory model: inputs change 1ns after the rising edge, accepts after ready_dly wait cycles.
    initial begin
        txn_t e;
        forever begin
            @(posedge clk);
            #1;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_fn(rd_addr);
                    stray_seen++;
                end
            end
            if (mem_req) begin
                if (wait_cnt >= ready_dly) begin
                    mem_ready = 1'b1;
                    wait_cnt  = 0;
                    if (txn_q.size() == 0) begin
                        chk("unexpected_txn", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = txn_q.pop_front();
                        chk("txn_we", mem_we, e.we);
                        chk("txn_addr", mem_addr, e.addr);
                        chk("txn_be", mem_be, e.be);
                        if (e.we) chk("txn_wdata", mem_wdata, e.wdata);
                    end
                    if (!mem_we) begin
                        rd_cnt  = resp_gap;
                        rd_addr = mem_addr;
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Response scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (if_rvalid) begin
                    if (if_exp_q.size() == 0) chk("if_rvalid_unexpected", 1, 0);
                    else chk("if_rdata", if_rdata, if_exp_q.pop_front());
                end
                if (dm_rvalid) begin
                    if (dm_exp_q.size() == 0) chk("dm_rvalid_unexpected", 1, 0);
                    else chk("dm_rdata", dm_rdata, dm_exp_q.pop_front());
                end
                if (dm_wack) begin
                    chk("dm_wack_expected", (wack_pend > 0), 1);
                    if (wack_pend > 0) wack_pend--;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, stalls, acc, rv, reqc, extra;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_dm_rvalid", dm_rvalid, 0);
        chk("rst_dm_wack", dm_wack, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Lone fetch, zero-wait memory
        @(posedge clk); #1;
        txn_q.push_back(mk_txn(1'b0, 32'h0, 32'h0, 4'hF));
        if_exp_q.push_back(32'h0050_0113);
        if_req = 1'b1; if_addr = 32'h0;
        @(negedge clk);
        cyc = 0; stalls = 0;
        while (!if_rvalid && cyc < 50) begin
            if (if_stall) stalls++;
            cyc++;
            @(negedge clk);
        end
        chk("t1_latency", cyc, 2);
        chk("t1_stall_cycles", stalls, 2);
        chk("t1_stall_at_rvalid", if_stall, 0);
        @(posedge clk); #1; if_req = 1'b0;
        @(negedge clk);
        chk("t1_rvalid_pulse", if_rvalid, 0);
        chk("t1_rdata_hold", if_rdata, 32'h0050_0113);

        // Simultaneous IF + DM load: DM first, IF in the following IDLE cycle
        @(posedge clk); #1;
        txn_q.push_back(mk_txn(1'b0, 32'd500, 32'h0, 4'hF));
        txn_q.push_back(mk_txn(1'b0, 32'h40, 32'h0, 4'hF));
        dm_exp_q.push_back(rd_fn(32'd500));
        if_exp_q.push_back(rd_fn(32'h40));
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd500; dm_be = 4'hF; dm_wdata = '0;
        @(negedge clk);
        chk("t2_idle", mem_req, 0);
        @(negedge clk);
        chk("t2_dm_req", mem_req, 1);
        chk("t2_dm_first", mem_addr, 32'd500);
        wait_rv(1, "t2_dm");
        @(posedge clk); #1; dm_req = 1'b0;
        @(negedge clk);
        chk("t2_idle_gap", mem_req, 0);
        @(negedge clk);
        chk("t2_if_req", mem_req, 1);
        chk("t2_if_addr", mem_addr, 32'h40);
        chk("t2_if_we", mem_we, 0);
        chk("t2_if_be", mem_be, 4'hF);
        wait_rv(0, "t2_if");
        @(posedge clk); #1; if_req = 1'b0;

        // Starvation: DM,DM,DM,IF,DM
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            txn_q.push_back(mk_txn(1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'hF));
            dm_exp_q.push_back(rd_fn(32'h200 + 32'(4 * k)));
        end
        txn_q.push_back(mk_txn(1'b0, 32'h80, 32'h0, 4'hF));
        if_exp_q.push_back(rd_fn(32'h80));
        txn_q.push_back(mk_txn(1'b0, 32'h20C, 32'h0, 4'hF));
        dm_exp_q.push_back(rd_fn(32'h20C));
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_addr = 32'h200;
        for (int k = 0; k < 3; k++) begin
            wait_rv(1, "t3_dm");
            @(posedge clk); #1; dm_addr = 32'h200 + 32'(4 * (k + 1));
        end
        wait_rv(0, "t3_if");
        @(posedge clk); #1; if_req = 1'b0;
        wait_rv(1, "t3_dm_last");
        @(posedge clk); #1; dm_req = 1'b0;
`ifdef ARB_PERF_CNT_EN
        chk("t3_perf_starve_hit", perf_starve_hit, 1);
`endif

        // Store with three wait cycles
        @(posedge clk); #1;
        ready_dly = 3;
        txn_q.push_back(mk_txn(1'b1, 32'd500, 32'd18, 4'hF));
        wack_pend++;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd500; dm_wdata = 32'd18; dm_be = 4'hF;
        reqc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_req) begin
                reqc++;
                chk("t4_addr", mem_addr, 32'd500);
                chk("t4_wdata", mem_wdata, 32'd18);
                chk("t4_be", mem_be, 4'hF);
                chk("t4_we", mem_we, 1);
                chk("t4_wack", dm_wack, mem_ready);
                chk("t4_stall", dm_stall, !mem_ready);
                if (mem_ready) break;
            end
        end
        chk("t4_req_cycles", reqc, 4);
        @(posedge clk); #1; dm_req = 1'b0; dm_we = 1'b0; ready_dly = 0;
        @(negedge clk);
        chk("t4_wack_once", dm_wack, 0);

        // Reset while waiting in RESP; the late read data must be dropped
        @(posedge clk); #1;
        resp_gap = 4; stray_seen = 0;
        txn_q.push_back(mk_txn(1'b0, 32'h44, 32'h0, 4'hF));
        if_req = 1'b1; if_addr = 32'h44;
        cyc = 0;
        @(negedge clk);
        while (!(mem_req && mem_ready) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_accept_in_time", (cyc < 50), 1);
        @(posedge clk); #3;
        rst = 1'b1; if_req = 1'b0;
        #1;
        chk("t5_mem_req", mem_req, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_mem_be", mem_be, 0);
        chk("t5_mem_we", mem_we, 0);
        chk("t5_mem_wdata", mem_wdata, 0);
        chk("t5_if_rdata", if_rdata, 0);
        chk("t5_dm_rdata", dm_rdata, 0);
        chk("t5_if_rvalid", if_rvalid, 0);
        @(posedge clk); #3; rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t5_no_if_rvalid", if_rvalid, 0);
            chk("t5_no_dm_rvalid", dm_rvalid, 0);
        end
        chk("t5_stray_delivered", stray_seen, 1);

        // Fetch with read data 5 cycles after accept
        @(posedge clk); #1;
        resp_gap = 5;
        txn_q.push_back(mk_txn(1'b0, 32'h48, 32'h0, 4'hF));
        if_exp_q.push_back(rd_fn(32'h48));
        if_req = 1'b1; if_addr = 32'h48;
        acc = -1; rv = -1;
        for (int c = 0; c < 40 && rv < 0; c++) begin
            @(negedge clk);
            if (mem_req && mem_ready) acc = c;
            if (if_rvalid) rv = c;
            else chk("t6_stall", if_stall, 1);
        end
        chk("t6_gap", rv - acc, 5);
        @(posedge clk); #1; if_req = 1'b0; resp_gap = 1;
        @(negedge clk);
        chk("t6_idle_req", mem_req, 0);
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            if (if_rvalid) extra++;
            @(negedge clk);
        end
        chk("t6_single_pulse", extra, 0);

        chk("drain_txn", txn_q.size(), 0);
        chk("drain_if", if_exp_q.size(), 0);
        chk("drain_dm", dm_exp_q.size(), 0);
        chk("drain_wack", wack_pend, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
